// File: rtl/secuenciador_instr.sv
// Instruction sequencer: loadable program store, PC and run/step FSM feeding one
// instruction per FETCH+EXEC pair to a single-cycle datapath.
module secuenciador_instr #(
   parameter int         AW      = 5,
   parameter logic [5:0] OP_HALT = 6'h3F,
   parameter logic [5:0] OP_BEQ  = 6'h04,
   parameter logic [5:0] OP_J    = 6'h02
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          step_mode,
   input  logic          step,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [31:0]   prog_data,
   input  logic          zf,
   output logic [31:0]   instruccion,
   output logic          ejecutar,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          done,
   output logic          fin_mem
);

   localparam int            DEPTH   = 2**AW;
   localparam logic [AW-1:0] PC_ONE  = AW'(1);
   localparam logic [AW-1:0] PC_LAST = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_HOLD,
      S_STOP
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic          fin_mem_q, fin_mem_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;

   logic [31:0]   mem [DEPTH];
   logic [31:0]   instr_q;

   logic          prog_open;
   logic          fetch_en;
   logic          is_halt, is_beq, is_j;
   logic          beq_taken;
   logic [AW-1:0] imm_w;
   logic [AW-1:0] pc_seq, br_target, j_target;

   // Program store: written only while the sequencer is parked, read once per FETCH.
   assign prog_open = (state_q == S_IDLE) || (state_q == S_STOP);
   assign fetch_en  = (state_q == S_FETCH);

   always_ff @(posedge clk) begin
      if (prog_we && prog_open) begin
         mem[prog_addr] <= prog_data;
      end
      if (fetch_en) begin
         instr_q <= mem[pc_q];
      end
   end

   // Instruction decode of the fetched word.
   assign is_halt   = (instr_q[31:26] == OP_HALT);
   assign is_beq    = (instr_q[31:26] == OP_BEQ);
   assign is_j      = (instr_q[31:26] == OP_J);
   assign beq_taken = is_beq && zf;

   // Sign-extend the 16-bit offset, then keep only the PC width so targets wrap.
   assign imm_w     = AW'(signed'(instr_q[15:0]));
   assign pc_seq    = pc_q + PC_ONE;
   assign br_target = pc_seq + imm_w;
   assign j_target  = instr_q[AW-1:0];

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      fin_mem_d = fin_mem_q;

      case (state_q)
         S_IDLE, S_STOP: begin
            if (start) begin
               state_d   = S_FETCH;
               pc_d      = '0;
               fin_mem_d = 1'b0;
            end
         end
         S_FETCH: begin
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (is_halt) begin
               state_d = S_STOP;
            end else if (beq_taken || is_j) begin
               pc_d    = beq_taken ? br_target : j_target;
               state_d = step_mode ? S_HOLD : S_FETCH;
            end else if (pc_q == PC_LAST) begin
               // Falling off the end of the store: stop on the last address.
               fin_mem_d = 1'b1;
               state_d   = S_STOP;
            end else begin
               pc_d    = pc_seq;
               state_d = step_mode ? S_HOLD : S_FETCH;
            end
         end
         S_HOLD: begin
            if (step || !step_mode) begin
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      done_d = (state_d == S_STOP) && (state_q != S_STOP);
      busy_d = (state_d == S_FETCH) || (state_d == S_EXEC) || (state_d == S_HOLD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         fin_mem_q <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         fin_mem_q <= fin_mem_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   // Qualified from the async-reset state, so a reset drops the commit in the same cycle
   // and the unreset fetch register never leaks onto the datapath.
   assign ejecutar    = (state_q == S_EXEC) && !is_halt;
   assign instruccion = ejecutar ? instr_q : 32'h0;
   assign pc          = pc_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign fin_mem     = fin_mem_q;

endmodule
